ps2_dev_tx: RTL and testbench

- PS/2 device-side transmitter (keyboard/mouse end of the link). It serialises scancode bytes into PS/2 frames on ps2_clk_o/ps2_dat_o.
- Used on the FPGA board and in system sims to drive the SoC's ps2_clk_i_pad/ps2_dat_i_pad receiver inputs.
- Bytes enter through a valid/ready push port into a small FIFO.
- Frames are 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.

---
 rtl/ps2_dev_tx.sv | 190 +++++++++++++++++++
 tb/tb_ps2_dev_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: queues bytes in a small FIFO and drives
// 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop) to a host.
//
// state | meaning
// IDLE  | lines released, waiting for a queued byte with inhibit low
// HIGH  | PS/2 clock high half-period, data already presented
// LOW   | PS/2 clock low half-period, host samples data
// GAP   | lines released for the post-frame/post-abort idle time
module ps2_dev_tx #(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_CYCLES  = 4000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  input  logic                          inhibit_i,
  output logic                          ps2_clk_o,
  output logic                          ps2_dat_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] HP_LOAD  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_BIT = 4'd10;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [10:0]     shreg_q, shreg_d;
  logic            clk_q, clk_d;
  logic            dat_q, dat_d;
  logic            done_d;
  logic            busy_d;
  logic            pop;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            ready_q;
  logic            nonempty_q;
  logic [7:0]      head_q;
  logic            push;

  assign push = tx_valid_i && ready_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= tx_data_i;
  end

  // Head byte and non-empty flag are registered, so a fresh push is seen
  // by the FSM one cycle after the level updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      nonempty_q <= 1'b0;
      head_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      ready_q    <= (level_d != DEPTH_L);
      nonempty_q <= (level_q != '0);
      head_q     <= mem[rd_ptr_q];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    clk_d     = clk_q;
    dat_d     = dat_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        clk_d = 1'b1;
        dat_d = 1'b1;
        if (nonempty_q && !inhibit_i) begin
          shreg_d   = {1'b1, ~^head_q, head_q, 1'b0};
          dat_d     = 1'b0;
          bit_idx_d = '0;
          cnt_d     = HP_LOAD;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (inhibit_i && bit_idx_q != LAST_BIT) begin
          clk_d   = 1'b1;
          dat_d   = 1'b1;
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else if (cnt_q == '0) begin
          clk_d   = 1'b0;
          cnt_d   = HP_LOAD;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LOW: begin
        if (inhibit_i && bit_idx_q != LAST_BIT) begin
          clk_d   = 1'b1;
          dat_d   = 1'b1;
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else if (cnt_q == '0) begin
          clk_d = 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            pop     = 1'b1;
            done_d  = 1'b1;
            dat_d   = 1'b1;
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            shreg_d   = {1'b0, shreg_q[10:1]};
            dat_d     = shreg_q[1];
            cnt_d     = HP_LOAD;
            state_d   = HIGH;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        clk_d = 1'b1;
        dat_d = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      clk_q        <= 1'b1;
      dat_q        <= 1'b1;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      clk_q        <= clk_d;
      dat_q        <= dat_d;
      frame_done_o <= done_d;
      busy_o       <= busy_d;
    end
  end

  assign ps2_clk_o    = clk_q;
  assign ps2_dat_o    = dat_q;
  assign tx_ready_o   = ready_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed self-checking bench for ps2_dev_tx with short timing parameters.
module tb_ps2_dev_tx;
  localparam int HP  = 4;
  localparam int GP  = 8;
  localparam int DEP = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       inhibit_i = 1'b0;
  logic       tx_ready_o, ps2_clk_o, ps2_dat_o, busy_o, frame_done_o;
  logic [2:0] fifo_level_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ps2_dev_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GP), .FIFO_DEPTH(DEP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .inhibit_i(inhibit_i), .ps2_clk_o(ps2_clk_o),
    .ps2_dat_o(ps2_dat_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .fifo_level_o(fifo_level_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk_i);
    tx_data_i = b; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  // Waits for the start bit, then records data at each falling PS/2 clock
  // until frame_done_o is seen.
  task automatic capture_frame(output logic [10:0] bits, output int falls, output int dones,
                               output int t_start, output int t_end);
    logic pc;
    int n;
    bits = '0; falls = 0; dones = 0; n = 0;
    while (ps2_dat_o !== 1'b0 && n < 400) begin @(negedge clk_i); n++; end
    t_start = cyc; pc = ps2_clk_o; n = 0;
    while (dones == 0 && n < 400) begin
      @(negedge clk_i); n++;
      if (pc === 1'b1 && ps2_clk_o === 1'b0) begin
        if (falls < 11) bits[falls] = ps2_dat_o;
        falls++;
      end
      pc = ps2_clk_o;
      if (frame_done_o === 1'b1) dones++;
    end
    t_end = cyc;
  endtask

  task automatic wait_falls(input int target, output bit ok);
    logic pc;
    int falls, n;
    falls = 0; n = 0; pc = ps2_clk_o;
    while (falls < target && n < 400) begin
      @(negedge clk_i); n++;
      if (pc === 1'b1 && ps2_clk_o === 1'b0) falls++;
      pc = ps2_clk_o;
    end
    ok = (falls == target);
  endtask

  task automatic wait_start(output bit ok);
    int n;
    n = 0;
    while (ps2_dat_o !== 1'b0 && n < 400) begin @(negedge clk_i); n++; end
    ok = (ps2_dat_o === 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (ps2_clk_o !== 1'b1) begin errors++; $display("FAIL reset_clk got %b exp 1", ps2_clk_o); end
    checks++; if (ps2_dat_o !== 1'b1) begin errors++; $display("FAIL reset_dat got %b exp 1", ps2_dat_o); end
    checks++; if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", tx_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done_o); end
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    logic [10:0] bits;
    int falls, dones, t0, t1;
    push_byte(8'h1C);
    checks++; if (fifo_level_o !== 3'd1) begin errors++; $display("FAIL basic_level1 got %0d exp 1", fifo_level_o); end
    checks++; if (ps2_dat_o !== 1'b1) begin errors++; $display("FAIL basic_lat_n0 got %b exp 1", ps2_dat_o); end
    @(negedge clk_i);
    checks++; if (ps2_dat_o !== 1'b1) begin errors++; $display("FAIL basic_lat_n1 got %b exp 1", ps2_dat_o); end
    @(negedge clk_i);
    checks++; if (ps2_dat_o !== 1'b0) begin errors++; $display("FAIL basic_lat_n2 got %b exp 0", ps2_dat_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy_o); end
    capture_frame(bits, falls, dones, t0, t1);
    checks++; if (bits !== 11'b10000111000) begin errors++; $display("FAIL basic_bits got %b exp %b", bits, 11'b10000111000); end
    checks++; if (falls != 11) begin errors++; $display("FAIL basic_falls got %0d exp 11", falls); end
    checks++; if (dones != 1) begin errors++; $display("FAIL basic_done got %0d exp 1", dones); end
    checks++; if (t1 - t0 != 88) begin errors++; $display("FAIL basic_span got %0d exp 88", t1 - t0); end
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("FAIL basic_level0 got %0d exp 0", fifo_level_o); end
    @(negedge clk_i);
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", frame_done_o); end
  endtask

  task automatic test_parity();
    logic [7:0]  pv [2] = '{8'hFF, 8'h00};
    logic [10:0] pe [2] = '{11'b11111111110, 11'b11000000000};
    logic [10:0] bits;
    int falls, dones, t0, t1;
    for (int i = 0; i < 2; i++) begin
      push_byte(pv[i]);
      capture_frame(bits, falls, dones, t0, t1);
      checks++; if (bits !== pe[i]) begin errors++; $display("FAIL parity_bits_%02h got %b exp %b", pv[i], bits, pe[i]); end
      checks++; if (falls != 11) begin errors++; $display("FAIL parity_falls_%02h got %0d exp 11", pv[i], falls); end
    end
  endtask

  task automatic test_fifo_full();
    repeat (20) @(negedge clk_i);
    fork
      begin
        int n;
        for (int i = 0; i < 4; i++) begin
          tx_data_i = 8'(8'hA1 + i); tx_valid_i = 1'b1;
          @(negedge clk_i);
        end
        checks++; if (tx_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", tx_ready_o); end
        checks++; if (fifo_level_o !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", fifo_level_o); end
        tx_data_i = 8'hA5;
        n = 0;
        while (tx_ready_o !== 1'b1 && n < 400) begin @(negedge clk_i); n++; end
        checks++; if (frame_done_o !== 1'b1) begin errors++; $display("FAIL full_a5_align done=%b exp 1", frame_done_o); end
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        checks++; if (fifo_level_o !== 3'd4) begin errors++; $display("FAIL full_a5_level got %0d exp 4", fifo_level_o); end
      end
      begin
        logic [10:0] bits;
        logic [7:0] exp_b;
        int falls, dones, t0, t1, prev_t1;
        prev_t1 = 0;
        for (int k = 0; k < 5; k++) begin
          capture_frame(bits, falls, dones, t0, t1);
          exp_b = 8'(8'hA1 + k);
          checks++; if (bits[8:1] !== exp_b || dones != 1) begin errors++; $display("FAIL full_order_%0d got %02h done %0d exp %02h done 1", k, bits[8:1], dones, exp_b); end
          if (k > 0) begin
            checks++; if (t0 - prev_t1 < GP) begin errors++; $display("FAIL full_gap_%0d got %0d exp >=%0d", k, t0 - prev_t1, GP); end
          end
          prev_t1 = t1;
        end
      end
    join
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", fifo_level_o); end
  endtask

  task automatic test_inhibit_mid();
    logic [10:0] bits;
    int falls, dones, t0, t1, t_abort, quiet;
    bit ok;
    repeat (20) @(negedge clk_i);
    push_byte(8'h5A);
    wait_start(ok);
    wait_falls(5, ok);
    checks++; if (!ok || ps2_clk_o !== 1'b0) begin errors++; $display("FAIL inh_reach ok=%b clk=%b exp 1/0", ok, ps2_clk_o); end
    inhibit_i = 1'b1;
    @(negedge clk_i);
    t_abort = cyc;
    checks++; if (ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1) begin errors++; $display("FAIL inh_abort clk=%b dat=%b exp 1/1", ps2_clk_o, ps2_dat_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL inh_nodone got %b exp 0", frame_done_o); end
    checks++; if (fifo_level_o !== 3'd1) begin errors++; $display("FAIL inh_level got %0d exp 1", fifo_level_o); end
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (i == 1) inhibit_i = 1'b0;
      if (ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1 || frame_done_o !== 1'b0) quiet++;
    end
    checks++; if (quiet != 0) begin errors++; $display("FAIL inh_gap_quiet got %0d active cycles exp 0", quiet); end
    capture_frame(bits, falls, dones, t0, t1);
    checks++; if (bits !== 11'b11010110100) begin errors++; $display("FAIL inh_retx_bits got %b exp %b", bits, 11'b11010110100); end
    checks++; if (dones != 1 || falls != 11) begin errors++; $display("FAIL inh_retx_done done %0d falls %0d exp 1/11", dones, falls); end
    checks++; if (t0 - t_abort < GP) begin errors++; $display("FAIL inh_retx_gap got %0d exp >=%0d", t0 - t_abort, GP); end
  endtask

  task automatic test_inhibit_stop_idle();
    logic [10:0] bits;
    int falls, dones, t0, t1, n, quiet, extra;
    logic pc;
    bit ok;
    repeat (20) @(negedge clk_i);
    push_byte(8'h3C);
    wait_start(ok);
    wait_falls(11, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_reach got %b exp 1", ok); end
    inhibit_i = 1'b1;
    n = 0; extra = 0; dones = 0; pc = ps2_clk_o;
    while (dones == 0 && n < 50) begin
      @(negedge clk_i); n++;
      if (pc === 1'b1 && ps2_clk_o === 1'b0) extra++;
      pc = ps2_clk_o;
      if (frame_done_o === 1'b1) dones++;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL stop_done got %0d exp 1", dones); end
    checks++; if (extra != 0) begin errors++; $display("FAIL stop_falls got %0d extra exp 0", extra); end
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("FAIL stop_level got %0d exp 0", fifo_level_o); end
    push_byte(8'h11);
    quiet = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1) quiet++;
    end
    checks++; if (quiet != 0) begin errors++; $display("FAIL idle_inh_quiet got %0d active cycles exp 0", quiet); end
    checks++; if (fifo_level_o !== 3'd1 || busy_o !== 1'b0) begin errors++; $display("FAIL idle_inh_hold level %0d busy %b exp 1/0", fifo_level_o, busy_o); end
    inhibit_i = 1'b0;
    capture_frame(bits, falls, dones, t0, t1);
    checks++; if (bits !== 11'b11000100010 || dones != 1) begin errors++; $display("FAIL idle_release got %b done %0d exp %b done 1", bits, dones, 11'b11000100010); end
  endtask

  task automatic test_reset_mid();
    int quiet;
    bit ok;
    repeat (20) @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      tx_data_i = 8'(8'h21 + i); tx_valid_i = 1'b1;
      @(negedge clk_i);
    end
    tx_valid_i = 1'b0;
    wait_start(ok);
    wait_falls(7, ok);
    checks++; if (!ok || fifo_level_o !== 3'd3) begin errors++; $display("FAIL rstmid_reach ok=%b level=%0d exp 1/3", ok, fifo_level_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++; if (ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1) begin errors++; $display("FAIL rstmid_lines clk=%b dat=%b exp 1/1", ps2_clk_o, ps2_dat_o); end
    checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("FAIL rstmid_level got %0d exp 0", fifo_level_o); end
    checks++; if (busy_o !== 1'b0 || tx_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_flags busy=%b ready=%b exp 0/1", busy_o, tx_ready_o); end
    quiet = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1 || frame_done_o !== 1'b0) quiet++;
    end
    checks++; if (quiet != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", quiet); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_fifo_full();
    test_inhibit_mid();
    test_inhibit_stop_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
